// File: rtl/mips_pkg.sv
// Shared MIPS-16 pipeline constants. The ID/EX, EX/MEM and MEM/WB stages and
// the forwarding unit all use these.
package mips_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = 3'd0;
endpackage

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result, commits it to the 8x16 register file,
// and serves two combinational read ports with same-cycle write-through bypass.
module wb_regfile #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_MemtoReg,
  input  logic [DATA_W-1:0] in_ReadData,
  input  logic [DATA_W-1:0] in_ALUResult,
  input  logic [ADDR_W-1:0] in_WriteRegister,
  input  logic              in_RegWrite,
  input  logic [ADDR_W-1:0] in_ReadReg1,
  input  logic [ADDR_W-1:0] in_ReadReg2,
  output logic [DATA_W-1:0] O_ReadData1,
  output logic [DATA_W-1:0] O_ReadData2,
  output logic [DATA_W-1:0] O_WriteData,
  output logic [CNT_W-1:0]  O_RetireCount
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(mips_pkg::ZERO_REG);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            wr_en;

  assign O_WriteData = in_MemtoReg ? in_ReadData : in_ALUResult;
  // wr_en depends only on RegWrite/address, so an X on MemtoReg cannot commit.
  assign wr_en = in_RegWrite && (in_WriteRegister != ZERO);

  function automatic logic [DATA_W-1:0] rd_port(
    input logic                            rst_v,
    input logic [ADDR_W-1:0]               addr,
    input logic                            we,
    input logic [ADDR_W-1:0]               waddr,
    input logic [DATA_W-1:0]               wdata,
    input logic [NUM_REGS-1:0][DATA_W-1:0] regs
  );
    if (rst_v || addr == ZERO) rd_port = '0;
    else if (we && waddr == addr) rd_port = wdata;
    else rd_port = regs[addr];
  endfunction

  assign O_ReadData1 = rd_port(rst, in_ReadReg1, wr_en, in_WriteRegister, O_WriteData, regs_q);
  assign O_ReadData2 = rd_port(rst, in_ReadReg2, wr_en, in_WriteRegister, O_WriteData, regs_q);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) regs_q[in_WriteRegister] <= O_WriteData;
      cnt_q <= cnt_d;
    end
  end

  assign O_RetireCount = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps plus random traffic
// against an array/counter reference model.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_MemtoReg;
  logic [15:0] in_ReadData, in_ALUResult;
  logic [2:0]  in_WriteRegister, in_ReadReg1, in_ReadReg2;
  logic        in_RegWrite;
  logic [15:0] O_ReadData1, O_ReadData2, O_WriteData, O_RetireCount;
  logic [15:0] s_rd1, s_rd2, s_wd;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rst(rst), .in_MemtoReg(in_MemtoReg), .in_ReadData(in_ReadData),
    .in_ALUResult(in_ALUResult), .in_WriteRegister(in_WriteRegister),
    .in_RegWrite(in_RegWrite), .in_ReadReg1(in_ReadReg1), .in_ReadReg2(in_ReadReg2),
    .O_ReadData1(O_ReadData1), .O_ReadData2(O_ReadData2), .O_WriteData(O_WriteData),
    .O_RetireCount(O_RetireCount)
  );

  wb_regfile #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_MemtoReg(in_MemtoReg), .in_ReadData(in_ReadData),
    .in_ALUResult(in_ALUResult), .in_WriteRegister(in_WriteRegister),
    .in_RegWrite(in_RegWrite), .in_ReadReg1(in_ReadReg1), .in_ReadReg2(in_ReadReg2),
    .O_ReadData1(s_rd1), .O_ReadData2(s_rd2), .O_WriteData(s_wd),
    .O_RetireCount(s_cnt)
  );

  logic [15:0] model [8];
  int unsigned cnt;
  bit          cnt_known = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic r, input logic rw, input logic [2:0] wr,
                                         input logic [15:0] wd, input logic [2:0] a);
    if (r || a == 3'd0) return 16'h0000;
    if (rw && wr == a) return wd;
    return model[a];
  endfunction

  // One cycle: drive after the falling edge, check the combinational view
  // before the rising edge, then update the model at the commit edge.
  task automatic step(input logic r, input logic rw, input logic mtr, input logic [2:0] wr,
                      input logic [15:0] rdv, input logic [15:0] alu,
                      input logic [2:0] r1, input logic [2:0] r2);
    logic [15:0] wd;
    @(negedge clk);
    rst = r; in_RegWrite = rw; in_MemtoReg = mtr; in_WriteRegister = wr;
    in_ReadData = rdv; in_ALUResult = alu; in_ReadReg1 = r1; in_ReadReg2 = r2;
    #2;
    wd = mtr ? rdv : alu;
    if (!$isunknown(mtr)) chk("wdata", {16'h0, O_WriteData}, {16'h0, wd});
    chk("rd1", {16'h0, O_ReadData1}, {16'h0, exp_rd(r, rw, wr, wd, r1)});
    chk("rd2", {16'h0, O_ReadData2}, {16'h0, exp_rd(r, rw, wr, wd, r2)});
    if (cnt_known) begin
      chk("retire", {16'h0, O_RetireCount}, cnt);
      chk("retire_sat4", {28'h0, s_cnt}, (cnt > 15) ? 32'd15 : cnt);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      cnt = 0;
      cnt_known = 1'b1;
    end else if (rw && wr != 3'd0) begin
      model[wr] = wd;
      cnt++;
    end
  endtask

  task automatic rand_step(input int rst_pct);
    step(($urandom_range(99) < rst_pct), 1'($urandom), 1'($urandom), 3'($urandom),
         16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, random writes, then reset for two cycles with a colliding write to r2
    step(1, 0, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 30; i++) rand_step(0);
    step(1, 1, 0, 3'd2, 16'h1111, 16'h2222, 2, 3);
    step(1, 1, 1, 3'd2, 16'h3333, 16'h4444, 2, 5);
    for (int i = 0; i < 8; i += 2) step(0, 0, 0, 0, 0, 0, 3'(i), 3'(i + 1));

    // Select/commit
    step(0, 1, 0, 3'd3, 16'hBEEF, 16'h1234, 0, 0);
    step(0, 1, 1, 3'd5, 16'hBEEF, 16'h1234, 3, 5);
    step(0, 0, 0, 0, 0, 0, 3, 5);
    chk("r3_after", {16'h0, O_ReadData1}, 32'h1234);
    chk("r5_after", {16'h0, O_ReadData2}, 32'hBEEF);
    chk("count_2", {16'h0, O_RetireCount}, 32'd2);

    // Bypass on both ports, then read back from storage
    step(0, 1, 0, 3'd4, 16'h0000, 16'hA5A5, 4, 4);
    step(0, 0, 0, 0, 0, 0, 4, 4);
    chk("r4_stored", {16'h0, O_ReadData1}, 32'hA5A5);

    // Zero register
    step(0, 1, 0, 3'd0, 16'h0000, 16'hFFFF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 3);

    // Write disabled: no bypass, no commit; X select must not corrupt state
    step(0, 0, 0, 3'd2, 16'h5555, 16'h6666, 2, 2);
    step(0, 0, 1'bx, 3'd2, 16'h7777, 16'h8888, 2, 4);
    step(0, 0, 0, 0, 0, 0, 2, 4);

    // Saturation of the 4-bit counter, then hold
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++)
      step(0, 1, 0, 3'($urandom_range(7, 1)), 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
    step(0, 0, 0, 0, 0, 0, 1, 7);
    chk("sat_held", {28'h0, s_cnt}, 32'd15);

    // Random traffic with occasional reset
    for (int i = 0; i < 300; i++) rand_step(4);
    step(0, 0, 0, 0, 0, 0, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
